// File: rtl/elevator_car_fsm.sv
// Elevator car controller: latches floor calls into a pending mask and serves them
// with a SCAN policy, stepping one floor per TRAVEL_TICKS timing strobes.
module elevator_car_fsm #(
   parameter int NUM_FLOORS   = 8,
   parameter int TRAVEL_TICKS = 4,
   parameter int DOOR_TICKS   = 6,
   localparam int FLOOR_W     = $clog2(NUM_FLOORS),
   localparam int MAX_TICKS   = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS,
   localparam int TIMER_W     = $clog2(MAX_TICKS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic [NUM_FLOORS-1:0] call_req,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic [NUM_FLOORS-1:0] destination,
   output logic [1:0]            sim_state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10,
      DOOR = 2'b11
   } state_t;

   state_t                  state_q, state_d;
   logic                    dirUp_q, dirUp_d;
   logic [TIMER_W-1:0]      timer_q, timer_d;
   logic [FLOOR_W-1:0]      floor_q, floor_d;
   logic [NUM_FLOORS-1:0]   pending_q, pending_d;
   logic [NUM_FLOORS-1:0]   pendNext;
   logic [NUM_FLOORS-1:0]   clrMask;
   logic [FLOOR_W-1:0]      stepFloor;

   // True when any request lies strictly beyond floor f in the given direction.
   function automatic logic anyBeyond(input logic [NUM_FLOORS-1:0] mask,
                                      input logic [FLOOR_W-1:0] f,
                                      input logic up);
      logic found;
      found = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (mask[i] && (up ? (i > int'(f)) : (i < int'(f))))
            found = 1'b1;
      end
      return found;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dirUp_q   <= 1'b1;
         timer_q   <= '0;
         floor_q   <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         dirUp_q   <= dirUp_d;
         timer_q   <= timer_d;
         floor_q   <= floor_d;
         pending_q <= pending_d;
      end
   end

   // Decisions look at pending_q merged with this cycle's calls so a fresh call counts at once.
   always_comb begin
      state_d   = state_q;
      dirUp_d   = dirUp_q;
      timer_d   = timer_q;
      floor_d   = floor_q;
      pendNext  = pending_q | call_req;
      stepFloor = (state_q == UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

      case (state_q)
         IDLE: begin
            if (pendNext[floor_q]) begin
               state_d = DOOR;
               timer_d = TIMER_W'(DOOR_TICKS);
            end else if (anyBeyond(pendNext, floor_q, dirUp_q)) begin
               state_d = dirUp_q ? UP : DOWN;
               timer_d = TIMER_W'(TRAVEL_TICKS);
            end else if (anyBeyond(pendNext, floor_q, !dirUp_q)) begin
               state_d = dirUp_q ? DOWN : UP;
               dirUp_d = !dirUp_q;
               timer_d = TIMER_W'(TRAVEL_TICKS);
            end
         end
         UP, DOWN: begin
            if (tick) begin
               if (timer_q == TIMER_W'(1)) begin
                  floor_d = stepFloor;
                  if (pendNext[stepFloor]) begin
                     state_d = DOOR;
                     timer_d = TIMER_W'(DOOR_TICKS);
                  end else if (anyBeyond(pendNext, stepFloor, state_q == UP)) begin
                     timer_d = TIMER_W'(TRAVEL_TICKS);
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  timer_d = timer_q - TIMER_W'(1);
               end
            end
         end
         DOOR: begin
            // A call at this floor re-opens the door for a full period.
            if (call_req[floor_q]) begin
               timer_d = TIMER_W'(DOOR_TICKS);
            end else if (tick) begin
               if (timer_q == TIMER_W'(1))
                  state_d = IDLE;
               else
                  timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      clrMask   = (state_d == DOOR) ? (NUM_FLOORS'(1) << floor_d) : '0;
      pending_d = pendNext & ~clrMask;
   end

   assign current_floor = floor_q;
   assign destination   = pending_q;
   assign sim_state     = state_q;

endmodule
